dmem_access_unit: RTL and testbench

- Sits between the core's MEM stage and a word-wide, synchronous-read data RAM that has a single write enable.
- Converts byte-addressed RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word RAM accesses.
- Sub-word loads: byte/halfword extraction with sign or zero extension.
- Sub-word stores: read-modify-write sequence that stalls the core.
- Misaligned accesses are detected and flagged.

---
 rtl/dmem_access_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_dmem_access_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// Data-memory access unit: turns byte-addressed RV32I loads/stores into word RAM accesses,
// with sub-word load formatting and a stalling read-modify-write path for SB/SH.
module dmem_access_unit #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              stall,
    output logic              misalign,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {StIdle, StRmwRd, StRmwWr} state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] req_idx;
    logic [1:0]        req_off;
    logic              unused_addr_hi;

    assign req_idx        = req_addr[ADDR_W+1:2];
    assign req_off        = req_addr[1:0];
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    // Load capture for the one-cycle-later formatting stage
    logic              ld_valid_q, ld_valid_d;
    logic [2:0]        ld_f3_q, ld_f3_d;
    logic [1:0]        ld_off_q, ld_off_d;

    // Read-modify-write context
    logic [ADDR_W-1:0] rmw_idx_q, rmw_idx_d;
    logic [1:0]        rmw_off_q, rmw_off_d;
    logic              rmw_half_q, rmw_half_d;
    logic [15:0]       rmw_data_q, rmw_data_d;
    logic [31:0]       merged_q, merged_d;
    logic [31:0]       merge_word;

    logic is_load, is_store, is_misal;

    // Request decode; unsupported funct3 leaves both is_load and is_store low
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_misal = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'd0: is_store = 1'b1;
                3'd1: begin
                    is_store = 1'b1;
                    is_misal = req_off[0];
                end
                3'd2: begin
                    is_store = 1'b1;
                    is_misal = |req_off;
                end
                default: ;
            endcase
        end else begin
            case (req_funct3)
                3'd0, 3'd4: is_load = 1'b1;
                3'd1, 3'd5: begin
                    is_load  = 1'b1;
                    is_misal = req_off[0];
                end
                3'd2: begin
                    is_load  = 1'b1;
                    is_misal = |req_off;
                end
                default: ;
            endcase
        end
    end

    // Insert the captured byte/halfword into the word read back from RAM
    always_comb begin
        merge_word = ram_rdata;
        if (rmw_half_q) begin
            if (rmw_off_q[1]) begin
                merge_word[31:16] = rmw_data_q;
            end else begin
                merge_word[15:0] = rmw_data_q;
            end
        end else begin
            case (rmw_off_q)
                2'd0: merge_word[7:0]   = rmw_data_q[7:0];
                2'd1: merge_word[15:8]  = rmw_data_q[7:0];
                2'd2: merge_word[23:16] = rmw_data_q[7:0];
                default: merge_word[31:24] = rmw_data_q[7:0];
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        ld_valid_d = 1'b0;
        ld_f3_d    = ld_f3_q;
        ld_off_d   = ld_off_q;
        rmw_idx_d  = rmw_idx_q;
        rmw_off_d  = rmw_off_q;
        rmw_half_d = rmw_half_q;
        rmw_data_d = rmw_data_q;
        merged_d   = merged_q;
        stall      = 1'b0;
        misalign   = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (is_misal) begin
                        misalign = 1'b1;
                    end else if (is_load) begin
                        ram_addr   = req_idx;
                        ld_valid_d = 1'b1;
                        ld_f3_d    = req_funct3;
                        ld_off_d   = req_off;
                    end else if (is_store && req_funct3 == 3'd2) begin
                        ram_we    = 1'b1;
                        ram_wdata = req_wdata;
                        ram_addr  = req_idx;
                    end else if (is_store) begin
                        ram_addr   = req_idx;
                        stall      = 1'b1;
                        rmw_idx_d  = req_idx;
                        rmw_off_d  = req_off;
                        rmw_half_d = req_funct3[0];
                        rmw_data_d = req_wdata[15:0];
                        state_d    = StRmwRd;
                    end
                end
            end
            StRmwRd: begin
                stall    = 1'b1;
                ram_addr = rmw_idx_q;
                merged_d = merge_word;
                state_d  = StRmwWr;
            end
            StRmwWr: begin
                ram_we    = 1'b1;
                ram_wdata = merged_q;
                ram_addr  = rmw_idx_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Reset also drops any write the FSM would otherwise issue this cycle
        if (RESET) begin
            stall     = 1'b0;
            misalign  = 1'b0;
            ram_we    = 1'b0;
            ram_addr  = '0;
            ram_wdata = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= StIdle;
            ld_valid_q <= 1'b0;
            ld_f3_q    <= '0;
            ld_off_q   <= '0;
            rmw_idx_q  <= '0;
            rmw_off_q  <= '0;
            rmw_half_q <= 1'b0;
            rmw_data_q <= '0;
            merged_q   <= '0;
        end else begin
            state_q    <= state_d;
            ld_valid_q <= ld_valid_d;
            ld_f3_q    <= ld_f3_d;
            ld_off_q   <= ld_off_d;
            rmw_idx_q  <= rmw_idx_d;
            rmw_off_q  <= rmw_off_d;
            rmw_half_q <= rmw_half_d;
            rmw_data_q <= rmw_data_d;
            merged_q   <= merged_d;
        end
    end

    // Load result formatting from the RAM word returned this cycle
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        case (ld_off_q)
            2'd0: ld_byte = ram_rdata[7:0];
            2'd1: ld_byte = ram_rdata[15:8];
            2'd2: ld_byte = ram_rdata[23:16];
            default: ld_byte = ram_rdata[31:24];
        endcase
        ld_half = ld_off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];

        rdata = '0;
        if (rdata_valid) begin
            case (ld_f3_q)
                3'd0: rdata = {{24{ld_byte[7]}}, ld_byte};
                3'd1: rdata = {{16{ld_half[15]}}, ld_half};
                3'd4: rdata = {24'h0, ld_byte};
                3'd5: rdata = {16'h0, ld_half};
                default: rdata = ram_rdata;
            endcase
        end
    end

    assign rdata_valid = ld_valid_q & ~RESET;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed test-plan steps then random traffic, checked against
// a word-array reference model of memory and the RV32I load/store rules.
module tb_dmem_access_unit;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          req_valid;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [31:0]   rdata;
    logic          rdata_valid;
    logic          stall;
    logic          misalign;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic          ram_we;
    logic [31:0]   ram_rdata;

    dmem_access_unit #(.ADDR_W(AW)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .stall      (stall),
        .misalign   (misalign),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata)
    );

    always #5 CLK = ~CLK;

    // Synchronous-read word RAM, with a preload port used only during reset
    logic [31:0]   ram [0:DEPTH-1];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_data;

    always @(posedge CLK) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        else if (pl_en) ram[pl_addr] <= pl_data;
        ram_rdata <= ram[ram_addr];
    end

    logic [31:0] ref_mem [0:DEPTH-1];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Access size in bytes, 0 for an unsupported funct3
    function automatic int access_size(input logic we, input logic [2:0] f3);
        if (we) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    // 0 = no-op, 1 = misaligned, 2 = performed
    function automatic int classify(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = access_size(we, f3);
        if (sz == 0) return 0;
        if ((int'(a[1:0]) % sz) != 0) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [2:0] f3,
                                             input int off);
        logic [31:0] v;
        if (f3 == 3'd2) return w;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else begin
            v = (w >> (16 * (off / 2))) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_merge(input logic [31:0] w, input logic [2:0] f3,
                                              input int off, input logic [31:0] wd);
        logic [31:0] mask;
        if (f3 == 3'd0) begin
            mask = 32'hFF << (8 * off);
            return (w & ~mask) | ((wd & 32'hFF) << (8 * off));
        end
        mask = 32'hFFFF << (8 * off);
        return (w & ~mask) | ((wd & 32'hFFFF) << (8 * off));
    endfunction

    task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        @(posedge CLK);
        #1;
        req_valid  = v;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] a);
        int cls, idx, off;
        cls = classify(1'b0, f3, a);
        idx = int'(a[AW+1:2]);
        off = int'(a[1:0]);
        drive(1'b1, 1'b0, f3, a, $urandom);
        @(negedge CLK);
        chk($sformatf("ld_mis f3=%0d a=%h", f3, a), 32'(misalign), 32'(cls == 1));
        chk("ld_stall", 32'(stall), 32'd0);
        chk("ld_we", 32'(ram_we), 32'd0);
        chk("ld_rv_early", 32'(rdata_valid), 32'd0);
        if (cls == 2) chk("ld_addr", 32'(ram_addr), 32'(idx));
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge CLK);
        chk($sformatf("ld_rv f3=%0d a=%h", f3, a), 32'(rdata_valid), 32'(cls == 2));
        chk($sformatf("ld_data f3=%0d a=%h", f3, a), rdata,
            (cls == 2) ? exp_load(ref_mem[idx], f3, off) : 32'd0);
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int cls, idx, off;
        logic [31:0] nw;
        cls = classify(1'b1, f3, a);
        idx = int'(a[AW+1:2]);
        off = int'(a[1:0]);
        drive(1'b1, 1'b1, f3, a, wd);
        @(negedge CLK);
        chk($sformatf("st_mis f3=%0d a=%h", f3, a), 32'(misalign), 32'(cls == 1));
        chk("st_rv", 32'(rdata_valid), 32'd0);
        if (cls == 2 && f3 == 3'd2) begin
            chk("sw_we", 32'(ram_we), 32'd1);
            chk("sw_wdata", ram_wdata, wd);
            chk("sw_addr", 32'(ram_addr), 32'(idx));
            chk("sw_stall", 32'(stall), 32'd0);
            ref_mem[idx] = wd;
        end else if (cls == 2) begin
            nw = exp_merge(ref_mem[idx], f3, off, wd);
            chk("rmw0_stall", 32'(stall), 32'd1);
            chk("rmw0_we", 32'(ram_we), 32'd0);
            chk("rmw0_addr", 32'(ram_addr), 32'(idx));
            // Requests are ignored outside idle, so scramble them
            drive(1'b1, 1'($urandom), 3'($urandom), $urandom, $urandom);
            @(negedge CLK);
            chk("rmw1_stall", 32'(stall), 32'd1);
            chk("rmw1_we", 32'(ram_we), 32'd0);
            chk("rmw1_addr", 32'(ram_addr), 32'(idx));
            chk("rmw1_rv", 32'(rdata_valid), 32'd0);
            drive(1'b1, 1'($urandom), 3'($urandom), $urandom, $urandom);
            @(negedge CLK);
            chk("rmw2_stall", 32'(stall), 32'd0);
            chk("rmw2_we", 32'(ram_we), 32'd1);
            chk($sformatf("rmw2_wdata f3=%0d a=%h", f3, a), ram_wdata, nw);
            chk("rmw2_addr", 32'(ram_addr), 32'(idx));
            chk("rmw2_rv", 32'(rdata_valid), 32'd0);
            ref_mem[idx] = nw;
        end else begin
            chk("st_nop_we", 32'(ram_we), 32'd0);
            chk("st_nop_stall", 32'(stall), 32'd0);
        end
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge CLK);
        chk("st_after_we", 32'(ram_we), 32'd0);
        chk("st_after_stall", 32'(stall), 32'd0);
        chk("st_after_rv", 32'(rdata_valid), 32'd0);
        chk("st_after_rdata", rdata, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        pl_en      = 1'b0;
        pl_addr    = '0;
        pl_data    = 32'd0;

        for (int i = 0; i < int'(DEPTH); i++) begin
            @(posedge CLK);
            #1;
            pl_en      = 1'b1;
            pl_addr    = AW'(i);
            pl_data    = (i == 4) ? 32'h8081_F2F3 : $urandom;
            ref_mem[i] = pl_data;
        end
        @(posedge CLK);
        #1;
        pl_en = 1'b0;
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_rv", 32'(rdata_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mis", 32'(misalign), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_wdata", ram_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);

        // Loads from word 4
        do_load(3'd2, 32'h10);
        do_load(3'd0, 32'h10);
        do_load(3'd4, 32'h13);
        do_load(3'd1, 32'h12);
        do_load(3'd5, 32'h10);

        // Sub-word and word stores
        do_store(3'd0, 32'h11, 32'h0000_00AA);
        do_load(3'd2, 32'h10);
        do_store(3'd1, 32'h12, 32'h0000_1234);
        do_load(3'd2, 32'h10);
        do_store(3'd2, 32'h10, 32'hDEAD_BEEF);
        do_load(3'd2, 32'h10);

        // Misaligned requests
        do_load(3'd2, 32'h11);
        do_store(3'd1, 32'h13, 32'h0000_5555);
        do_load(3'd1, 32'h01);
        do_load(3'd2, 32'h10);
        do_load(3'd2, 32'h00);

        // Back-to-back word loads
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(1'b1, 1'b0, 3'd2, 32'(4 * i), $urandom);
            else drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
            @(negedge CLK);
            chk("b2b_stall", 32'(stall), 32'd0);
            chk($sformatf("b2b_rv %0d", i), 32'(rdata_valid), 32'(i > 0));
            if (i > 0) chk($sformatf("b2b_data %0d", i - 1), rdata, ref_mem[i - 1]);
        end

        // Reset in the RMW_RD cycle of an SB aborts the write
        drive(1'b1, 1'b1, 3'd0, 32'h10, 32'h0000_0055);
        @(negedge CLK);
        chk("abort_stall0", 32'(stall), 32'd1);
        @(posedge CLK);
        #1;
        RESET     = 1'b1;
        req_valid = 1'b0;
        @(negedge CLK);
        chk("abort_we_rst", 32'(ram_we), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("abort_stall", 32'(stall), 32'd0);
        chk("abort_we", 32'(ram_we), 32'd0);
        chk("abort_rv", 32'(rdata_valid), 32'd0);
        do_load(3'd2, 32'h10);

        // Random traffic over the low 64 words, high address bits exercise the wrap
        for (int i = 0; i < 200; i++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            f3 = 3'($urandom);
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) do_store(f3, a, $urandom);
            else do_load(f3, a);
        end

        for (int i = 0; i < 64; i++) do_load(3'd2, 32'(4 * i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
